// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - register-file instruction controller: fetch operands, execute, write back.
module exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        mem_we,
    output logic [2:0]  mem_opcode,
    output logic [3:0]  mem_destino,
    output logic [3:0]  mem_addr1,
    output logic [3:0]  mem_addr2,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out1,
    input  logic [15:0] mem_data_out2,
    output logic [15:0] result,
    output logic        ovf,
    output logic        done
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_SHOW  = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [3:0]  dest_q;
    logic        accept;
    logic        short_op;
    logic        enter_write;
    logic [2:0]  wr_op;
    logic [3:0]  wr_dest;
    logic [15:0] wr_result;
    logic        wr_ovf;
    logic        wr_we;
    logic        wr_clr;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [31:0] prod;

    assign accept   = (state == IDLE) && instr_valid;
    assign short_op = (instr[15:13] == OP_LOAD) || (instr[15:13] == OP_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = short_op ? WRITE : READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LOAD/CLEAR enter WRITE straight from IDLE, so their fields come from instr, not the latch.
    always_comb begin
        instr_ready = (state == IDLE);
        wr_op       = (state == IDLE) ? instr[15:13] : op_q;
        wr_dest     = (state == IDLE) ? instr[12:9]  : dest_q;
        enter_write = (state == EXEC) || (accept && short_op);
        sum         = 17'(mem_data_out1) + 17'(mem_data_out2);
        diff        = 17'(mem_data_out1) - 17'(mem_data_out2);
        prod        = 32'(mem_data_out1) * 32'(mem_data_out2);
        wr_result   = 16'h0000;
        wr_ovf      = 1'b0;
        case (wr_op)
            OP_LOAD:  wr_result = {7'b0, instr[8:0]};
            OP_ADD:   {wr_ovf, wr_result} = sum;
            OP_SUB:   {wr_ovf, wr_result} = diff;
            OP_AND:   wr_result = mem_data_out1 & mem_data_out2;
            OP_OR:    wr_result = mem_data_out1 | mem_data_out2;
            OP_MUL: begin
                wr_result = prod[15:0];
                wr_ovf    = |prod[31:16];
            end
            OP_SHOW:  wr_result = mem_data_out1;
            default:  wr_result = 16'h0000;
        endcase
        wr_we  = (wr_op != OP_SHOW) && (wr_op != OP_CLEAR);
        wr_clr = (wr_op == OP_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_LOAD;
            dest_q      <= 4'h0;
            mem_addr1   <= 4'h0;
            mem_addr2   <= 4'h0;
            mem_we      <= 1'b0;
            mem_opcode  <= 3'b000;
            mem_destino <= 4'h0;
            mem_data_in <= 16'h0000;
            result      <= 16'h0000;
            ovf         <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= instr[15:13];
                dest_q    <= instr[12:9];
                mem_addr1 <= instr[8:5];
                mem_addr2 <= instr[4:1];
            end
            done       <= enter_write;
            mem_we     <= enter_write && wr_we;
            mem_opcode <= (enter_write && wr_clr) ? OP_CLEAR : 3'b000;
            if (enter_write) begin
                result <= wr_result;
                ovf    <= wr_ovf;
                if (wr_we) begin
                    mem_destino <= wr_dest;
                    mem_data_in <= wr_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - directed and randomized checks of exec_ctrl against a register-file model.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_we;
    logic [2:0]  mem_opcode;
    logic [3:0]  mem_destino;
    logic [3:0]  mem_addr1;
    logic [3:0]  mem_addr2;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out1;
    logic [15:0] mem_data_out2;
    logic [15:0] result;
    logic        ovf;
    logic        done;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] rf [16];
    logic [15:0] model [16];

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_we(mem_we), .mem_opcode(mem_opcode),
        .mem_destino(mem_destino), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_data_in(mem_data_in), .mem_data_out1(mem_data_out1),
        .mem_data_out2(mem_data_out2), .result(result), .ovf(ovf), .done(done)
    );

    // Synchronous-read register file as seen by the controller.
    always @(posedge clk) begin
        if (mem_opcode == 3'b110) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (mem_we) begin
            rf[mem_destino] <= mem_data_in;
        end
        mem_data_out1 <= rf[mem_addr1];
        mem_data_out2 <= rf[mem_addr2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_opcode"}, 32'(mem_opcode), 32'd0);
        chk({tag, "_destino"}, 32'(mem_destino), 32'd0);
        chk({tag, "_addr1"}, 32'(mem_addr1), 32'd0);
        chk({tag, "_addr2"}, 32'(mem_addr2), 32'd0);
        chk({tag, "_data_in"}, 32'(mem_data_in), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready_timeout"}, 32'(guard < 20), 32'd1);
    endtask

    task automatic do_instr(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [8:0] imm);
        logic [15:0] a, b, er;
        logic [31:0] wide;
        logic        eovf, ewe;
        int          elat, lat, we_cnt, clr_cnt;
        a    = model[s1];
        b    = model[s2];
        eovf = 1'b0;
        er   = 16'h0000;
        case (op)
            3'd0: er = {7'b0, imm};
            3'd1: begin wide = 32'(a) + 32'(b); er = wide[15:0]; eovf = wide > 32'hFFFF; end
            3'd2: begin er = a - b; eovf = a < b; end
            3'd3: er = a & b;
            3'd4: er = a | b;
            3'd5: begin wide = 32'(a) * 32'(b); er = wide[15:0]; eovf = wide > 32'hFFFF; end
            3'd6: er = 16'h0000;
            default: er = a;
        endcase
        ewe  = (op != 3'd6) && (op != 3'd7);
        elat = (op == 3'd0 || op == 3'd6) ? 1 : 3;
        wait_ready($sformatf("op%0d", op));
        instr       = (op == 3'd0) ? {op, d, imm} : {op, d, s1, s2, 1'b0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        lat = 0; we_cnt = 0; clr_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1 && elat == 3) begin
                chk("addr1", 32'(mem_addr1), 32'(s1));
                chk("addr2", 32'(mem_addr2), 32'(s2));
            end
            we_cnt  += int'(mem_we);
            clr_cnt += int'(mem_opcode == 3'b110);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("latency_op%0d", op), 32'(lat), 32'(elat));
        chk($sformatf("result_op%0d", op), 32'(result), 32'(er));
        if (op != 3'd6) chk($sformatf("ovf_op%0d", op), 32'(ovf), 32'(eovf));
        if (ewe) begin
            chk("destino", 32'(mem_destino), 32'(d));
            chk("data_in", 32'(mem_data_in), 32'(er));
        end
        @(negedge clk);
        we_cnt  += int'(mem_we);
        clr_cnt += int'(mem_opcode == 3'b110);
        chk("done_pulse", 32'(done), 32'd0);
        chk($sformatf("we_cycles_op%0d", op), 32'(we_cnt), 32'(ewe));
        chk($sformatf("clr_cycles_op%0d", op), 32'(clr_cnt), 32'(op == 3'd6));
        if (ewe) model[d] = er;
        if (op == 3'd6) for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    initial begin
        int rdy_cnt, done_cnt, we_cnt;
        rst         = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        do_instr(3'd6, 4'd0, 4'd0, 4'd0, 9'd0);
        do_instr(3'd0, 4'd3, 4'd0, 4'd0, 9'h1FF);
        do_instr(3'd0, 4'd1, 4'd0, 4'd0, 9'd5);
        do_instr(3'd0, 4'd2, 4'd0, 4'd0, 9'd7);
        do_instr(3'd1, 4'd4, 4'd1, 4'd2, 9'd0);
        chk("r4_add", 32'(model[4]), 32'h000C);

        do_instr(3'd0, 4'd1, 4'd0, 4'd0, 9'd0);
        do_instr(3'd0, 4'd2, 4'd0, 4'd0, 9'd1);
        do_instr(3'd2, 4'd1, 4'd1, 4'd2, 9'd0);
        do_instr(3'd1, 4'd5, 4'd1, 4'd2, 9'd0);
        do_instr(3'd2, 4'd6, 4'd2, 4'd1, 9'd0);

        do_instr(3'd0, 4'd1, 4'd0, 4'd0, 9'h100);
        do_instr(3'd0, 4'd2, 4'd0, 4'd0, 9'h100);
        do_instr(3'd5, 4'd7, 4'd1, 4'd2, 9'd0);
        do_instr(3'd7, 4'd0, 4'd7, 4'd0, 9'd0);

        do_instr(3'd6, 4'd0, 4'd0, 4'd0, 9'd0);
        do_instr(3'd7, 4'd0, 4'd5, 4'd0, 9'd0);

        for (int n = 0; n < 60; n++) begin
            do_instr(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                     9'($urandom));
        end

        do_instr(3'd0, 4'd9, 4'd0, 4'd0, 9'($urandom));
        do_instr(3'd0, 4'd10, 4'd0, 4'd0, 9'($urandom));
        wait_ready("stream");
        instr       = {3'd1, 4'd8, 4'd9, 4'd10, 1'b0};
        instr_valid = 1'b1;
        rdy_cnt = 0; done_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            rdy_cnt  += int'(instr_ready);
            done_cnt += int'(done);
            we_cnt   += int'(mem_we);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        model[8] = model[9] + model[10];
        chk("stream_ready_cycles", 32'(rdy_cnt), 32'd4);
        chk("stream_done_pulses", 32'(done_cnt), 32'd4);
        chk("stream_we_cycles", 32'(we_cnt), 32'd4);
        do_instr(3'd7, 4'd0, 4'd8, 4'd0, 9'd0);

        do_instr(3'd0, 4'd12, 4'd0, 4'd0, 9'h0AB);
        wait_ready("rst_exec");
        instr       = {3'd1, 4'd12, 4'd9, 4'd10, 1'b0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_exec_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_exec");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_we", 32'(mem_we), 32'd0);
        do_instr(3'd7, 4'd0, 4'd12, 4'd0, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with the clock port named clk and the reset port named rst.
REQ-002 SHALL have the following ports:
  clk  in  1  clock; all state changes on rising edge.
  rst  in  1  synchronous active-high reset.
  instr  in  16  instruction word: [15:13] op, [12:9] dest, [8:5] src1, [4:1] src2, [8:0] imm9 (LOAD only).
  instr_valid  in  1  instr present.
  instr_ready  out  1  controller can accept.
  mem_we  out  1  register-file write enable.
  mem_opcode  out  3  register-file opcode; 3'b110 clears all 16 entries.
  mem_destino  out  4  write address.
  mem_addr1  out  4  read address, port 1.
  mem_addr2  out  4  read address, port 2.
  mem_data_in  out  16  write data.
  mem_data_out1  in  16  read data, port 1; valid one clk after addr1 is sampled.
  mem_data_out2  in  16  read data, port 2; same timing as port 1.
  result  out  16  last completed result.
  ovf  out  1  overflow/carry of last arithmetic op.
  done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL decode op as: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MUL, 110 CLEAR, 111 SHOW.
REQ-004 SHALL implement FSM states IDLE, READ, EXEC and WRITE.
REQ-005 SHALL drive instr_ready=1 only in IDLE.
REQ-006 SHALL accept an instruction on a rising edge where instr_valid && instr_ready, latching op, dest, src1, src2 and imm9.
REQ-007 SHALL, on acceptance of ADD/SUB/AND/OR/MUL/SHOW: set mem_addr1=src1 and mem_addr2=src2 at the accepting edge, then go IDLE->READ->EXEC->WRITE->IDLE.
REQ-008 SHALL, on acceptance of LOAD or CLEAR: go IDLE->WRITE->IDLE.
REQ-009 SHALL hold mem_addr1/mem_addr2 stable from acceptance until the next acceptance.
REQ-010 SHALL, in EXEC, compute from mem_data_out1 (A) and mem_data_out2 (B), registering the result at the EXEC->WRITE edge:
  - ADD: A+B; ovf = carry out of bit 15.
  - SUB: A-B; ovf = borrow (A<B unsigned).
  - AND, OR: bitwise; ovf=0.
  - MUL: low 16 bits of A*B; ovf = (upper 16 bits != 0).
  - SHOW: result=A; ovf=0.
REQ-011 SHALL, for LOAD, produce result = {7'b0, imm9} and ovf=0.
REQ-012 SHALL, in WRITE for LOAD/ADD/SUB/AND/OR/MUL, drive mem_we=1, mem_destino=dest and mem_data_in=result.
REQ-013 SHALL, in WRITE for SHOW, drive mem_we=0.
REQ-014 SHALL, in WRITE for CLEAR, drive mem_we=0 and mem_opcode=3'b110, and set result=0.
REQ-015 SHALL drive mem_opcode=3'b000 in every state other than WRITE-for-CLEAR.
REQ-016 SHALL keep mem_we=1 and mem_opcode=110 registered outputs, each asserted for exactly one cycle per instruction.
REQ-017 SHALL assert done=1 exactly during the WRITE cycle, and update result/ovf at the edge entering WRITE.
REQ-018 SHALL hold result/ovf until the next WRITE entry.
REQ-019 SHALL give latency (accept edge to done high) of 3 cycles for 3-read ops and 1 cycle for LOAD/CLEAR.
REQ-020 SHALL give a maximum throughput of one instruction per 4 cycles (2 for LOAD/CLEAR).
REQ-021 SHALL ensure read-after-write to the same register across consecutive instructions returns the new value; this follows because the earliest next READ occurs after the WRITE edge commits.
REQ-022 SHALL ignore instr_valid asserted outside IDLE: no latch and no side effect.
REQ-023 SHALL allow dest to equal src1 or src2: sources are read before the write.
REQ-024 SHALL treat all arithmetic as unsigned modulo 2^16.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, go to IDLE and set instr_ready=1, mem_we=0, mem_opcode=000, mem_destino=0, mem_addr1=0, mem_addr2=0, mem_data_in=0, result=0, ovf=0, done=0.
REQ-026 SHALL let a write or clear already presented in WRITE complete at the reset edge (the register file samples that same edge).
REQ-027 SHALL, on reset in READ or EXEC, abandon the instruction with no write.
REQ-028 SHALL have rst take priority over instr_valid.

Verification
REQ-029 SHALL cover LOAD r3,0x1FF: done 1 cycle after accept, mem_we=1, destino=3, data_in=0x01FF, result=0x01FF.
REQ-030 SHALL cover LOAD r1,5; LOAD r2,7; ADD r4,r1,r2: r4 written 0x000C, ovf=0, done 3 cycles after ADD accept.
REQ-031 SHALL cover r1=0xFFFF, r2=0x0001, ADD r5,r1,r2 -> result 0x0000, ovf=1; then SUB r6,r2,r1 -> 0x0002, ovf=1.
REQ-032 SHALL cover r1=0x0100, r2=0x0100, MUL r7,r1,r2 -> result 0x0000, ovf=1; then SHOW r7 -> result 0x0000, mem_we never asserted.
REQ-033 SHALL cover CLEAR: mem_opcode=110 for exactly 1 cycle, mem_we=0; subsequent SHOW of any register -> 0x0000.
REQ-034 SHALL cover instr_valid held high continuously (ready=1 every 4th cycle, no extra accepts), plus rst asserted in EXEC of an ADD (no write, all outputs at reset values next cycle).
